ecc_serial_host: RTL and testbench

- Host-side serial initiator for the ECC core wrapper's bit-serial job interface.
- Accepts a parallel scalar-multiplication job, serializes it onto the wrapper's serial input pins (valid pulse, mode, operands, MSB first).
- Deserializes the wrapper's serial result and returns it as a parallel response.
- Sits between a parallel host/bus adapter and the wrapper; tracks the wrapper's alternating full-job / point-only-job stage.

---
 rtl/ecc_serial_host.sv | 216 +++++++++++++++++++++
 tb/tb_ecc_serial_host.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ecc_serial_host.sv
// Host-side serial initiator for the ECC core wrapper's bit-serial job interface.
// Serializes a parallel job onto the wrapper pins and deserializes the serial result.
module ecc_serial_host #(
  parameter int unsigned MAX_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_mode,
  input  logic [MAX_BITS-1:0] req_a,
  input  logic [MAX_BITS-1:0] req_prime,
  input  logic [MAX_BITS-1:0] req_mul,
  input  logic [MAX_BITS-1:0] req_px,
  input  logic [MAX_BITS-1:0] req_py,
  output logic                o_data_valid,
  output logic                o_mode,
  output logic                o_a,
  output logic                o_prime,
  output logic                o_mul,
  output logic                o_Pointx,
  output logic                o_Pointy,
  input  logic                i_data_valid,
  input  logic                i_Pointx,
  input  logic                i_Pointy,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [MAX_BITS-1:0] rsp_x,
  output logic [MAX_BITS-1:0] rsp_y,
  output logic                stage,
  output logic                err_unexp
);

  localparam int unsigned CntW = $clog2(MAX_BITS);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [2:0] {
    StIdle, StSendValid, StSendMode, StSendData, StWaitRes, StRecv, StResp
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                stage_q, stage_d;
  logic [1:0]          mode_q;
  logic [MAX_BITS-1:0] a_q, prime_q, mul_q, px_q, py_q;
  logic [MAX_BITS-1:0] rx_q, rx_d, ry_q, ry_d;
  logic [CntW-1:0]     n_m1;
  logic                accept;

  logic dv_q, mode_bit_q, a_bit_q, prime_bit_q, mul_bit_q, px_bit_q, py_bit_q, err_q;
  logic dv_d, mode_bit_d, a_bit_d, prime_bit_d, mul_bit_d, px_bit_d, py_bit_d, err_d;

  assign accept = (state_q == StIdle) && req_valid;

  // Operand width minus one, from the latched mode
  always_comb begin
    case (mode_q)
      2'b00:   n_m1 = CntW'(15);
      2'b01:   n_m1 = CntW'(31);
      2'b10:   n_m1 = CntW'(63);
      default: n_m1 = CntW'(127);
    endcase
  end

  // State, counters, job operands, result shifters and registered serial outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      stage_q     <= 1'b0;
      mode_q      <= 2'b01;
      a_q         <= '0;
      prime_q     <= '0;
      mul_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      dv_q        <= 1'b0;
      mode_bit_q  <= 1'b0;
      a_bit_q     <= 1'b0;
      prime_bit_q <= 1'b0;
      mul_bit_q   <= 1'b0;
      px_bit_q    <= 1'b0;
      py_bit_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      dv_q        <= dv_d;
      mode_bit_q  <= mode_bit_d;
      a_bit_q     <= a_bit_d;
      prime_bit_q <= prime_bit_d;
      mul_bit_q   <= mul_bit_d;
      px_bit_q    <= px_bit_d;
      py_bit_q    <= py_bit_d;
      err_q       <= err_d;
      if (accept) begin
        px_q <= req_px;
        py_q <= req_py;
        // The wrapper retains mode/a/prime/mul across a point-only job
        if (!stage_q) begin
          mode_q  <= req_mode;
          a_q     <= req_a;
          prime_q <= req_prime;
          mul_q   <= req_mul;
        end
      end
    end
  end

  // Next-state, counter, stage and result-shift logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StSendValid;
          rx_d    = '0;
          ry_d    = '0;
        end
      end
      StSendValid: begin
        if (stage_q) begin
          state_d = StSendData;
          cnt_d   = n_m1;
        end else begin
          state_d = StSendMode;
          cnt_d   = CntOne;
        end
      end
      StSendMode: begin
        if (cnt_q == '0) begin
          state_d = StSendData;
          cnt_d   = n_m1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StSendData: begin
        if (cnt_q == '0) begin
          state_d = StWaitRes;
          stage_d = ~stage_q;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StWaitRes: begin
        // First strobe already carries the MSB
        if (i_data_valid) begin
          rx_d    = {rx_q[MAX_BITS-2:0], i_Pointx};
          ry_d    = {ry_q[MAX_BITS-2:0], i_Pointy};
          state_d = StRecv;
          cnt_d   = n_m1;
        end
      end
      StRecv: begin
        // cnt_q counts bits still to come; gaps in the strobe are simply waited out
        if (i_data_valid) begin
          rx_d = {rx_q[MAX_BITS-2:0], i_Pointx};
          ry_d = {ry_q[MAX_BITS-2:0], i_Pointy};
          if (cnt_q == CntOne) state_d = StResp;
          else                 cnt_d   = cnt_q - CntOne;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Serial output bits for the next cycle, selected from the upcoming state and bit index
  always_comb begin
    dv_d        = (state_d == StSendValid);
    mode_bit_d  = 1'b0;
    a_bit_d     = 1'b0;
    prime_bit_d = 1'b0;
    mul_bit_d   = 1'b0;
    px_bit_d    = 1'b0;
    py_bit_d    = 1'b0;
    if (state_d == StSendMode) mode_bit_d = mode_q[cnt_d[0]];
    if (state_d == StSendData) begin
      px_bit_d = px_q[cnt_d];
      py_bit_d = py_q[cnt_d];
      if (!stage_q) begin
        a_bit_d     = a_q[cnt_d];
        prime_bit_d = prime_q[cnt_d];
        mul_bit_d   = mul_q[cnt_d];
      end
    end
    err_d = i_data_valid && (state_q != StWaitRes) && (state_q != StRecv);
  end

  assign req_ready    = (state_q == StIdle);
  assign rsp_valid    = (state_q == StResp);
  assign rsp_x        = rsp_valid ? rx_q : '0;
  assign rsp_y        = rsp_valid ? ry_q : '0;
  assign stage        = stage_q;
  assign err_unexp    = err_q;
  assign o_data_valid = dv_q;
  assign o_mode       = mode_bit_q;
  assign o_a          = a_bit_q;
  assign o_prime      = prime_bit_q;
  assign o_mul        = mul_bit_q;
  assign o_Pointx     = px_bit_q;
  assign o_Pointy     = py_bit_q;

endmodule

// File: tb/tb_ecc_serial_host.sv
// Directed, table-driven bench for ecc_serial_host.
module tb_ecc_serial_host;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [1:0]   req_mode;
  logic [127:0] req_a, req_prime, req_mul, req_px, req_py;
  logic         o_data_valid, o_mode, o_a, o_prime, o_mul, o_Pointx, o_Pointy;
  logic         i_data_valid, i_Pointx, i_Pointy;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_x, rsp_y;
  logic         stage, err_unexp;

  int checks = 0;
  int errors = 0;
  logic m_stage = 1'b0;

  typedef struct {
    logic [1:0]   mode;
    logic [127:0] a, prime, mul, px, py;
    logic [127:0] res_x, res_y;
    int           gap_at, gap_len, hold;
    int           exp_n;
    logic         exp_stage;
  } job_t;

  job_t jobs[6];

  ecc_serial_host #(.MAX_BITS(128)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_a(req_a), .req_prime(req_prime), .req_mul(req_mul), .req_px(req_px), .req_py(req_py),
    .o_data_valid(o_data_valid), .o_mode(o_mode), .o_a(o_a), .o_prime(o_prime), .o_mul(o_mul),
    .o_Pointx(o_Pointx), .o_Pointy(o_Pointy),
    .i_data_valid(i_data_valid), .i_Pointx(i_Pointx), .i_Pointy(i_Pointy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .stage(stage), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected {req_ready, dv, mode, a, prime, mul, px, py} at cycle k after acceptance
  function automatic logic [7:0] exp_frame(input logic full, input int n, input int k,
                                           input job_t j);
    logic [7:0] v;
    int b;
    v = 8'h00;
    if (k == 0) v[6] = 1'b1;
    else if (full) begin
      if (k == 1) v[5] = j.mode[1];
      else if (k == 2) v[5] = j.mode[0];
      else if (k <= n + 2) begin
        b = n + 2 - k;
        v[4:0] = {j.a[b], j.prime[b], j.mul[b], j.px[b], j.py[b]};
      end
    end else if (k <= n) begin
      b = n - k;
      v[1:0] = {j.px[b], j.py[b]};
    end
    return v;
  endfunction

  task automatic run_job(input job_t j);
    logic full;
    int n;
    full = ~m_stage;
    n = j.exp_n;
    check("pre_req_ready", 128'(req_ready), 128'(1));
    check("pre_stage", 128'(stage), 128'(m_stage));
    req_mode = j.mode; req_a = j.a; req_prime = j.prime; req_mul = j.mul;
    req_px = j.px; req_py = j.py; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k <= n + 4; k++) begin
      check($sformatf("frame_k%0d", k),
            128'({req_ready, o_data_valid, o_mode, o_a, o_prime, o_mul, o_Pointx, o_Pointy}),
            128'(exp_frame(full, n, k, j)));
      tick();
    end
    check("stage_after_send", 128'(stage), 128'(j.exp_stage));
    for (int i = 0; i < n; i++) begin
      if (i == j.gap_at) begin
        i_data_valid = 1'b0;
        repeat (j.gap_len) tick();
      end
      if (i == n - 1) check("rsp_valid_early", 128'(rsp_valid), 128'(0));
      i_data_valid = 1'b1;
      i_Pointx = j.res_x[n-1-i];
      i_Pointy = j.res_y[n-1-i];
      tick();
    end
    i_data_valid = 1'b0; i_Pointx = 1'b0; i_Pointy = 1'b0;
    check("rsp_valid", 128'(rsp_valid), 128'(1));
    check("rsp_x", rsp_x, j.res_x);
    check("rsp_y", rsp_y, j.res_y);
    check("err_in_recv", 128'(err_unexp), 128'(0));
    if (j.hold > 0) begin
      repeat (j.hold) tick();
      check("hold_valid", 128'(rsp_valid), 128'(1));
      check("hold_x", rsp_x, j.res_x);
      check("hold_y", rsp_y, j.res_y);
      check("hold_req_ready", 128'(req_ready), 128'(0));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_rsp_valid", 128'(rsp_valid), 128'(0));
    check("post_req_ready", 128'(req_ready), 128'(1));
    m_stage = j.exp_stage;
  endtask

  initial begin
    jobs[0] = '{mode: 2'b00, a: 128'd2, prime: 128'd17, mul: 128'd2, px: 128'd5, py: 128'd1,
                res_x: 128'h6, res_y: 128'h3, gap_at: -1, gap_len: 0, hold: 5,
                exp_n: 16, exp_stage: 1'b1};
    jobs[1] = '{mode: 2'b11, a: 128'hFFFF, prime: 128'hFFFF, mul: 128'hFFFF,
                px: 128'h000A, py: 128'h0006,
                res_x: 128'h1234, res_y: 128'hBEEF, gap_at: -1, gap_len: 0, hold: 0,
                exp_n: 16, exp_stage: 1'b0};
    jobs[2] = '{mode: 2'b11, a: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                prime: 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF61,
                mul: 128'h8000_0000_0000_0000_0000_0000_0000_0001,
                px: 128'h8000_0000_0000_0000_0000_0000_0000_0000,
                py: 128'h5555_AAAA_5555_AAAA_0F0F_F0F0_3C3C_C3C3,
                res_x: 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0001,
                res_y: 128'h8000_0000_0000_0000_0000_0000_0000_0003,
                gap_at: 40, gap_len: 3, hold: 2, exp_n: 128, exp_stage: 1'b1};
    jobs[3] = '{mode: 2'b00, a: 128'h0, prime: 128'h0, mul: 128'h0,
                px: 128'hDEAD_BEEF_0000_0001_8000_0000_CAFE_F00D,
                py: 128'h0000_0000_0000_0000_0000_0000_0000_0001,
                res_x: 128'h0000_0000_0000_0000_0000_0000_0000_0007,
                res_y: 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
                gap_at: 0, gap_len: 2, hold: 0, exp_n: 128, exp_stage: 1'b0};
    jobs[4] = '{mode: 2'b01, a: 128'h1357_9BDF, prime: 128'hFFFF_FFFB, mul: 128'h8000_0001,
                px: 128'hDEAD_BEEF, py: 128'h0F0F_0F0F,
                res_x: 128'h8765_4321, res_y: 128'h0000_0001, gap_at: 31, gap_len: 1, hold: 1,
                exp_n: 32, exp_stage: 1'b1};
    jobs[5] = '{mode: 2'b00, a: 128'hFFFF, prime: 128'hFFFF, mul: 128'hFFFF,
                px: 128'hC000_0003, py: 128'h7FFF_FFFE,
                res_x: 128'hFFFF_FFFF, res_y: 128'h0000_8000, gap_at: -1, gap_len: 0, hold: 0,
                exp_n: 32, exp_stage: 1'b0};

    rst = 1'b0; req_valid = 1'b0; req_mode = 2'b00;
    req_a = '0; req_prime = '0; req_mul = '0; req_px = '0; req_py = '0;
    i_data_valid = 1'b0; i_Pointx = 1'b0; i_Pointy = 1'b0; rsp_ready = 1'b0;
    tick();
    tick();
    check("reset_outputs",
          128'({o_data_valid, o_mode, o_a, o_prime, o_mul, o_Pointx, o_Pointy,
                rsp_valid, stage, err_unexp}), 128'(0));
    check("reset_req_ready", 128'(req_ready), 128'(1));
    check("reset_rsp_x", rsp_x, 128'(0));
    rst = 1'b1;
    tick();

    for (int t = 0; t < 6; t++) run_job(jobs[t]);

    // Stray result strobe while idle
    i_data_valid = 1'b1; i_Pointx = 1'b1; i_Pointy = 1'b1;
    tick();
    i_data_valid = 1'b0; i_Pointx = 1'b0; i_Pointy = 1'b0;
    check("err_pulse", 128'(err_unexp), 128'(1));
    check("err_no_state_change", 128'({req_ready, rsp_valid, o_data_valid}), 128'(3'b100));
    tick();
    check("err_one_cycle", 128'(err_unexp), 128'(0));

    // Reset in the middle of a 32-bit full job
    req_mode = 2'b01; req_a = 128'hFFFF_FFFF; req_prime = 128'hFFFF_FFFF;
    req_mul = 128'hFFFF_FFFF; req_px = 128'hFFFF_FFFF; req_py = 128'hFFFF_FFFF;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    check("mid_job_bits", 128'({o_a, o_prime, o_mul, o_Pointx, o_Pointy, req_ready}),
          128'(6'b111110));
    rst = 1'b0;
    tick();
    check("abort_outputs",
          128'({o_data_valid, o_mode, o_a, o_prime, o_mul, o_Pointx, o_Pointy,
                rsp_valid, stage, err_unexp}), 128'(0));
    check("abort_req_ready", 128'(req_ready), 128'(1));
    rst = 1'b1;
    repeat (3) tick();
    check("abort_stays_idle", 128'({req_ready, o_data_valid, o_Pointx}), 128'(3'b100));
    m_stage = 1'b0;
    run_job(jobs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
